// File: rtl/vend_checkout_engine_if.sv
// Vending checkout engine port bundle: front-end commands in, totals/status out.
// The master side is whoever owns the key/voice/IR front ends (or a bench); the
// slave side is the checkout engine itself.
interface vend_checkout_engine_if #(
    parameter int unsigned NUM_KEYS = 3,
    parameter int unsigned DIGITS   = 2
);
    // Front-end commands
    logic [NUM_KEYS-1:0] key_n;
    logic [2:0]          sel_code;
    logic                confirm_ir;
    logic                cancel;

    // Display and servo side
    logic [4*DIGITS-1:0] pay_bcd;
    logic [4*DIGITS-1:0] item_bcd;
    logic [4*DIGITS-1:0] change_bcd;
    logic                change_ok;
    logic                short_fund;
    logic                overflow;
    logic                busy;
    logic                dispense;

    modport master (
        output key_n,
        output sel_code,
        output confirm_ir,
        output cancel,
        input  pay_bcd,
        input  item_bcd,
        input  change_bcd,
        input  change_ok,
        input  short_fund,
        input  overflow,
        input  busy,
        input  dispense
    );

    modport slave (
        input  key_n,
        input  sel_code,
        input  confirm_ir,
        input  cancel,
        output pay_bcd,
        output item_bcd,
        output change_bcd,
        output change_ok,
        output short_fund,
        output overflow,
        output busy,
        output dispense
    );
endinterface

// File: rtl/vend_checkout_engine.sv
// Vending checkout engine: debounced coin keys and voice/IR commands feed
// 1-deep pending slots; an FSM adds coin/item values into BCD totals one count
// per clock, subtracts pay-item digit-serially, and drives a timed dispense pulse.
module vend_checkout_engine #(
    parameter int unsigned                NUM_KEYS    = 3,
    parameter logic [8*NUM_KEYS-1:0]      COIN_VALS   = 24'h0A_01_05,
    parameter int unsigned                NUM_ITEMS   = 4,
    parameter logic [8*NUM_ITEMS-1:0]     PRICES      = 32'h0A_08_05_03,
    parameter int unsigned                DIGITS      = 2,
    parameter int unsigned                DB_CYCLES   = 64,
    parameter int unsigned                DISP_CYCLES = 16
) (
    input logic                   clock,
    input logic                   clr,
    vend_checkout_engine_if.slave bus
);

    localparam int unsigned W       = 4 * DIGITS;
    localparam int unsigned DbW     = $clog2(DB_CYCLES + 1);
    localparam int unsigned DispW   = $clog2(DISP_CYCLES + 1);
    localparam int unsigned IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [W-1:0] AllNine = {DIGITS{4'h9}};
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StAdd, StSub, StDisp} state_e;

    // ---------------------------------------------------------------------
    // Key synchronisers and debouncers
    // ---------------------------------------------------------------------
    logic [NUM_KEYS-1:0] sync1_q, sync2_q, samp_q, lvl_q;
    logic [DbW-1:0]      db_cnt_q [NUM_KEYS];
    logic [NUM_KEYS-1:0] press;

    // 2-FF sync, then a per-key stability counter that latches the level when it hits 1
    always_ff @(posedge clock) begin
        if (clr) begin
            sync1_q <= '1;
            sync2_q <= '1;
            samp_q  <= '1;
            lvl_q   <= '1;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q <= bus.key_n;
            sync2_q <= sync1_q;
            samp_q  <= sync2_q;
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                if (sync2_q[k] != samp_q[k]) begin
                    db_cnt_q[k] <= DbW'(DB_CYCLES);
                end else if (db_cnt_q[k] != '0) begin
                    db_cnt_q[k] <= db_cnt_q[k] - DbW'(1);
                    if (db_cnt_q[k] == DbW'(1)) begin
                        lvl_q[k] <= sync2_q[k];
                    end
                end
            end
        end
    end

    // Press = debounced level about to go 1->0 this clock
    always_comb begin
        press = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            press[k] = (sync2_q[k] == samp_q[k]) && (db_cnt_q[k] == DbW'(1)) &&
                       lvl_q[k] && !sync2_q[k];
        end
    end

    // ---------------------------------------------------------------------
    // Voice / IR command decode
    // ---------------------------------------------------------------------
    logic       armed_q, ir_q, conf_q;
    logic       sel_arm, sel_conf, item_hit, item_evt, confirm_evt;
    logic [7:0] item_price;
    logic       cancel_clr;
    state_e     state_q, state_d;

    // Item code lookup, arm/confirm decode and edge detection
    always_comb begin
        item_hit   = 1'b0;
        item_price = '0;
        for (int unsigned c = 1; c <= NUM_ITEMS; c++) begin
            if (bus.sel_code == 3'(c)) begin
                item_hit   = 1'b1;
                item_price = PRICES[8*(c-1) +: 8];
            end
        end
        sel_arm     = (bus.sel_code == 3'd7);
        sel_conf    = (bus.sel_code == 3'd6);
        item_evt    = armed_q && item_hit;
        confirm_evt = (bus.confirm_ir && !ir_q) || (sel_conf && !conf_q);
        // Cancel has no effect while the servo is running
        cancel_clr  = bus.cancel && (state_q != StDisp);
    end

    // Arm flag and previous-level registers for confirm edge detection
    always_ff @(posedge clock) begin
        if (clr) begin
            armed_q <= 1'b0;
            ir_q    <= 1'b0;
            conf_q  <= 1'b0;
        end else begin
            ir_q   <= bus.confirm_ir;
            conf_q <= sel_conf;
            if (cancel_clr) begin
                armed_q <= 1'b0;
            end else if (sel_arm) begin
                armed_q <= 1'b1;
            end else if (item_evt) begin
                armed_q <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Pending event slots
    // ---------------------------------------------------------------------
    logic [NUM_KEYS-1:0] key_pend_q, key_take;
    logic                item_pend_q, item_take;
    logic [7:0]          item_val_q;

    // One slot per source; a new event while the slot is full is dropped
    always_ff @(posedge clock) begin
        if (clr || cancel_clr) begin
            key_pend_q  <= '0;
            item_pend_q <= 1'b0;
            item_val_q  <= '0;
        end else begin
            key_pend_q  <= (key_pend_q & ~key_take) | (press & ~key_pend_q);
            item_pend_q <= (item_pend_q & ~item_take) | (item_evt & ~item_pend_q);
            if (item_evt && !item_pend_q) begin
                item_val_q <= item_price;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Checkout FSM and BCD datapath
    // ---------------------------------------------------------------------
    logic [W-1:0]      pay_q, pay_d, item_q, item_d, change_q, change_d, diff_q, diff_d;
    logic              ok_q, ok_d, short_q, short_d, ovf_q, ovf_d;
    logic [7:0]        rem_q, rem_d;
    logic              tgt_q, tgt_d; // 0: pay total, 1: item total
    logic [IdxW-1:0]   sub_idx_q, sub_idx_d;
    logic              borrow_q, borrow_d;
    logic [DispW-1:0]  disp_cnt_q, disp_cnt_d;
    logic              busy_q, disp_q;

    logic [NUM_KEYS-1:0] key_onehot;
    logic                key_any;
    logic [7:0]          key_val;
    logic [3:0]          dig_a, dig_b, dig_r;
    logic [4:0]          dig_t;
    logic                dig_neg;
    logic [W-1:0]        diff_new;
    logic                clear_all;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Lowest-index pending key and the current subtract digit
    always_comb begin
        key_onehot = '0;
        key_any    = 1'b0;
        key_val    = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (key_pend_q[k] && !key_any) begin
                key_any       = 1'b1;
                key_onehot[k] = 1'b1;
                key_val       = COIN_VALS[8*k +: 8];
            end
        end
        dig_a    = pay_q[4*sub_idx_q +: 4];
        dig_b    = item_q[4*sub_idx_q +: 4];
        dig_t    = {1'b0, dig_a} - {1'b0, dig_b} - {4'b0, borrow_q};
        dig_neg  = dig_t[4];
        dig_r    = dig_neg ? (dig_t[3:0] + 4'd10) : dig_t[3:0];
        diff_new = diff_q;
        diff_new[4*sub_idx_q +: 4] = dig_r;
    end

    // Next state and datapath updates
    always_comb begin
        state_d    = state_q;
        pay_d      = pay_q;
        item_d     = item_q;
        change_d   = change_q;
        ok_d       = ok_q;
        short_d    = short_q;
        ovf_d      = ovf_q;
        rem_d      = rem_q;
        tgt_d      = tgt_q;
        sub_idx_d  = sub_idx_q;
        borrow_d   = borrow_q;
        diff_d     = diff_q;
        disp_cnt_d = disp_cnt_q;
        key_take   = '0;
        item_take  = 1'b0;
        clear_all  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cancel) begin
                    clear_all = 1'b1;
                end else if (confirm_evt && ok_q) begin
                    state_d    = StDisp;
                    disp_cnt_d = DispW'(DISP_CYCLES);
                end else if (item_pend_q || key_any) begin
                    // Item path has priority over coins
                    if (item_pend_q) begin
                        item_take = 1'b1;
                        rem_d     = item_val_q;
                        tgt_d     = 1'b1;
                    end else begin
                        key_take = key_onehot;
                        rem_d    = key_val;
                        tgt_d    = 1'b0;
                    end
                    sub_idx_d = '0;
                    borrow_d  = 1'b0;
                    diff_d    = '0;
                    // A zero value skips straight to the subtract pass
                    state_d   = (rem_d == 8'd0) ? StSub : StAdd;
                end
            end
            StAdd: begin
                if (bus.cancel) begin
                    clear_all = 1'b1;
                end else if ((tgt_q ? item_q : pay_q) == AllNine) begin
                    ovf_d   = 1'b1;
                    state_d = StSub;
                end else begin
                    if (tgt_q) begin
                        item_d = bcd_inc(item_q);
                    end else begin
                        pay_d = bcd_inc(pay_q);
                    end
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = StSub;
                    end
                end
            end
            StSub: begin
                if (bus.cancel) begin
                    clear_all = 1'b1;
                end else if (sub_idx_q == LastIdx) begin
                    state_d = StIdle;
                    if (dig_neg) begin
                        short_d  = 1'b1;
                        ok_d     = 1'b0;
                        change_d = '1;
                    end else begin
                        short_d  = 1'b0;
                        change_d = diff_new;
                        ok_d     = (item_q != '0);
                    end
                end else begin
                    sub_idx_d = sub_idx_q + IdxW'(1);
                    borrow_d  = dig_neg;
                    diff_d    = diff_new;
                end
            end
            StDisp: begin
                if (disp_cnt_q == DispW'(1)) begin
                    clear_all = 1'b1;
                end else begin
                    disp_cnt_d = disp_cnt_q - DispW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear_all) begin
            state_d  = StIdle;
            pay_d    = '0;
            item_d   = '0;
            change_d = '0;
            ok_d     = 1'b0;
            short_d  = 1'b0;
            ovf_d    = 1'b0;
        end
    end

    // FSM state, totals, flags and registered busy/dispense
    always_ff @(posedge clock) begin
        if (clr) begin
            state_q    <= StIdle;
            pay_q      <= '0;
            item_q     <= '0;
            change_q   <= '0;
            ok_q       <= 1'b0;
            short_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rem_q      <= '0;
            tgt_q      <= 1'b0;
            sub_idx_q  <= '0;
            borrow_q   <= 1'b0;
            diff_q     <= '0;
            disp_cnt_q <= '0;
            busy_q     <= 1'b0;
            disp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pay_q      <= pay_d;
            item_q     <= item_d;
            change_q   <= change_d;
            ok_q       <= ok_d;
            short_q    <= short_d;
            ovf_q      <= ovf_d;
            rem_q      <= rem_d;
            tgt_q      <= tgt_d;
            sub_idx_q  <= sub_idx_d;
            borrow_q   <= borrow_d;
            diff_q     <= diff_d;
            disp_cnt_q <= disp_cnt_d;
            busy_q     <= (state_d != StIdle);
            disp_q     <= (state_d == StDisp);
        end
    end

    assign bus.pay_bcd    = pay_q;
    assign bus.item_bcd   = item_q;
    assign bus.change_bcd = change_q;
    assign bus.change_ok  = ok_q;
    assign bus.short_fund = short_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = busy_q;
    assign bus.dispense   = disp_q;

endmodule

// File: tb/tb_vend_checkout_engine.sv
// Directed bench for vend_checkout_engine: a small model of the totals pushes
// expected snapshots into a queue as stimulus is driven; snapshots are popped
// and compared once the engine has finished the matching transaction.
module tb_vend_checkout_engine;

    logic clock = 1'b0;
    logic clr;

    always #5 clock = ~clock;

    vend_checkout_engine_if #(.NUM_KEYS(3), .DIGITS(2)) bus ();

    vend_checkout_engine dut (
        .clock (clock),
        .clr   (clr),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] pay;
        logic [7:0] item;
        logic [7:0] change;
        logic       ok;
        logic       shrt;
        logic       ovf;
    } snap_t;

    snap_t sb_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    m_pay  = 0;
    int    m_item = 0;
    bit    m_ovf  = 1'b0;
    int    coin  [3] = '{5, 1, 10};
    int    price [5] = '{0, 3, 5, 8, 10};

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.pay  = to_bcd(m_pay);
        s.item = to_bcd(m_item);
        s.ovf  = m_ovf;
        if (m_item > m_pay) begin
            s.change = 8'hFF;
            s.shrt   = 1'b1;
            s.ok     = 1'b0;
        end else begin
            s.change = to_bcd(m_pay - m_item);
            s.shrt   = 1'b0;
            s.ok     = (m_item != 0);
        end
        return s;
    endfunction

    task automatic model_key(input int k);
        if (m_pay + coin[k] > 99) begin
            m_pay = 99;
            m_ovf = 1'b1;
        end else begin
            m_pay = m_pay + coin[k];
        end
    endtask

    task automatic model_clear();
        m_pay  = 0;
        m_item = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic check_pop(input string tag);
        snap_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed empty scoreboard expected a pending snapshot", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".pay"},    32'(bus.pay_bcd),    32'(e.pay));
        chk({tag, ".item"},   32'(bus.item_bcd),   32'(e.item));
        chk({tag, ".change"}, 32'(bus.change_bcd), 32'(e.change));
        chk({tag, ".ok"},     32'(bus.change_ok),  32'(e.ok));
        chk({tag, ".short"},  32'(bus.short_fund), 32'(e.shrt));
        chk({tag, ".ovf"},    32'(bus.overflow),   32'(e.ovf));
        chk({tag, ".busy"},   32'(bus.busy),       32'd0);
    endtask

    task automatic wait_busy(input logic lvl, input int bound, input string tag);
        int n = 0;
        while (bus.busy !== lvl && n < bound) begin
            tick(1);
            n++;
        end
        chk({tag, ".busy_wait"}, 32'(bus.busy), 32'(lvl));
    endtask

    task automatic key_tap(input int k, input string tag);
        model_key(k);
        sb_q.push_back(model_snap());
        bus.key_n[k] = 1'b0;
        tick(100);
        bus.key_n[k] = 1'b1;
        tick(100);
        check_pop(tag);
    endtask

    task automatic say(input logic [2:0] c);
        bus.sel_code = c;
        tick(2);
        bus.sel_code = 3'd0;
        tick(2);
    endtask

    task automatic order_item(input int code, input string tag);
        if (m_item + price[code] > 99) begin
            m_item = 99;
            m_ovf  = 1'b1;
        end else begin
            m_item = m_item + price[code];
        end
        sb_q.push_back(model_snap());
        say(3'd7);
        say(3'(code));
        tick(20);
        check_pop(tag);
    endtask

    task automatic do_cancel(input string tag);
        model_clear();
        sb_q.push_back(model_snap());
        bus.cancel = 1'b1;
        tick(1);
        bus.cancel = 1'b0;
        tick(1);
        check_pop(tag);
    endtask

    // Waits for dispense, measures its length; a non-zero expectation also
    // checks the all-zero state that follows.
    task automatic expect_dispense(input int exp_len, input string tag);
        int n = 0;
        int c = 0;
        while (bus.dispense !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        while (bus.dispense === 1'b1 && c < 100) begin
            c++;
            tick(1);
        end
        chk({tag, ".disp_len"}, 32'(c), 32'(exp_len));
        if (exp_len != 0) begin
            model_clear();
            sb_q.push_back(model_snap());
            tick(1);
            check_pop({tag, ".after"});
        end
    endtask

    initial begin
        int blen;
        clr            = 1'b1;
        bus.key_n      = 3'b111;
        bus.sel_code   = 3'd0;
        bus.confirm_ir = 1'b0;
        bus.cancel     = 1'b0;
        tick(3);
        chk("rst.pay",    32'(bus.pay_bcd),    32'h0);
        chk("rst.item",   32'(bus.item_bcd),   32'h0);
        chk("rst.change", 32'(bus.change_bcd), 32'h0);
        chk("rst.flags",  32'({bus.change_ok, bus.short_fund, bus.overflow}), 32'h0);
        chk("rst.busy",   32'(bus.busy),       32'h0);
        chk("rst.disp",   32'(bus.dispense),   32'h0);
        clr = 1'b0;
        tick(2);

        // Bounced key0 press, then bounced release: exactly one 5-count event
        model_key(0);
        sb_q.push_back(model_snap());
        for (int i = 0; i < 3; i++) begin
            bus.key_n[0] = 1'b0;
            tick(10);
            bus.key_n[0] = 1'b1;
            tick(10);
        end
        bus.key_n[0] = 1'b0;
        wait_busy(1'b1, 200, "bounce");
        blen = 0;
        while (bus.busy === 1'b1 && blen < 50) begin
            blen++;
            tick(1);
        end
        chk("bounce.busy_len", 32'(blen), 32'd7);
        tick(10);
        for (int i = 0; i < 2; i++) begin
            bus.key_n[0] = 1'b1;
            tick(10);
            bus.key_n[0] = 1'b0;
            tick(10);
        end
        bus.key_n[0] = 1'b1;
        tick(150);
        check_pop("bounce");
        do_cancel("cancel1");

        // Item 2 then two key0 coins, IR confirm dispenses
        order_item(2, "it2");
        key_tap(0, "t2.k0a");
        key_tap(0, "t2.k0b");
        bus.confirm_ir = 1'b1;
        expect_dispense(16, "t2.ir");
        bus.confirm_ir = 1'b0;
        tick(2);

        // Item 4 paid exactly with key2, voice confirm dispenses
        order_item(4, "it4");
        key_tap(2, "t3.k2");
        bus.sel_code = 3'd6;
        expect_dispense(16, "t3.voice");
        bus.sel_code = 3'd0;
        tick(2);

        // Item 3 underpaid: confirm must not dispense
        order_item(3, "it3");
        key_tap(1, "t4.k1a");
        key_tap(1, "t4.k1b");
        bus.confirm_ir = 1'b1;
        expect_dispense(0, "t4.ir");
        bus.confirm_ir = 1'b0;
        chk("t4.still_short", 32'(bus.short_fund), 32'd1);
        do_cancel("cancel2");

        // Ten key2 coins saturate pay at 99 and set overflow
        for (int i = 0; i < 10; i++) begin
            key_tap(2, $sformatf("sat%0d", i));
        end
        do_cancel("cancel3");

        // Simultaneous key0+key2 with an unarmed item code: key0 serviced first
        model_key(0);
        sb_q.push_back(model_snap());
        model_key(2);
        sb_q.push_back(model_snap());
        bus.key_n    = 3'b010;
        bus.sel_code = 3'd2;
        wait_busy(1'b1, 200, "dual.a");
        wait_busy(1'b0, 50, "dual.a_end");
        check_pop("dual.k0");
        wait_busy(1'b1, 5, "dual.b");
        wait_busy(1'b0, 50, "dual.b_end");
        check_pop("dual.k2");
        bus.sel_code = 3'd0;
        bus.key_n    = 3'b111;
        tick(100);
        chk("dual.item_unarmed", 32'(bus.item_bcd), 32'h0);

        // Reset in the middle of an ADD pass
        bus.key_n[2] = 1'b0;
        wait_busy(1'b1, 200, "clr_mid");
        tick(3);
        clr       = 1'b1;
        bus.key_n = 3'b111;
        tick(1);
        chk("clr.pay",    32'(bus.pay_bcd),    32'h0);
        chk("clr.item",   32'(bus.item_bcd),   32'h0);
        chk("clr.change", 32'(bus.change_bcd), 32'h0);
        chk("clr.flags",  32'({bus.change_ok, bus.short_fund, bus.overflow}), 32'h0);
        chk("clr.busy",   32'(bus.busy),       32'h0);
        chk("clr.disp",   32'(bus.dispense),   32'h0);
        clr = 1'b0;
        model_clear();
        tick(100);
        chk("clr.quiet_pay", 32'(bus.pay_bcd), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
